// File: rtl/acc_breg_alu.sv
// acc_breg_alu: 8-bit SAP accumulator and B register with add/subtract ALU and a priority bus mux.
// The ALU sees only registered A/B, so bus_out can feed bus_in without forming a loop.
module acc_breg_alu (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] bus_in,
    input  logic [7:0] prog_in,
    input  logic       acc_we,
    input  logic       acc_load,
    input  logic       acc_oe,
    input  logic       breg_we,
    input  logic       breg_load,
    input  logic       breg_oe,
    input  logic       alu_oe,
    input  logic       SUB,
    output logic [7:0] acc_q,
    output logic [7:0] breg_q,
    output logic [7:0] alu_q,
    output logic       carry,
    output logic       zero,
    output logic [7:0] bus_out,
    output logic       bus_drive,
    output logic       bus_conflict
);
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [8:0] sum;

    always_comb begin
        a_d = acc_we ? bus_in : acc_load ? prog_in : a_q;
        b_d = breg_we ? bus_in : breg_load ? prog_in : b_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            a_q <= 8'h00;
            b_q <= 8'h00;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Subtraction as A + ~B + 1, so carry out means no borrow.
    assign sum    = {1'b0, a_q} + {1'b0, SUB ? ~b_q : b_q} + {8'h00, SUB};
    assign alu_q  = sum[7:0];
    assign carry  = sum[8];
    assign zero   = (alu_q == 8'h00);
    assign acc_q  = a_q;
    assign breg_q = b_q;

    assign bus_out      = alu_oe ? alu_q : breg_oe ? b_q : acc_oe ? a_q : 8'h00;
    assign bus_drive    = alu_oe | breg_oe | acc_oe;
    assign bus_conflict = (alu_oe & breg_oe) | (alu_oe & acc_oe) | (breg_oe & acc_oe);
endmodule

// File: tb/tb_acc_breg_alu.sv
// tb_acc_breg_alu: directed checks of acc_breg_alu with hand-computed expectations.
module tb_acc_breg_alu;
    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] bus_drv, prog_in;
    logic       loop_en;
    logic       acc_we, acc_load, acc_oe, breg_we, breg_load, breg_oe, alu_oe, SUB;
    logic [7:0] bus_in, acc_q, breg_q, alu_q, bus_out;
    logic       carry, zero, bus_drive, bus_conflict;
    int         total = 0;
    int         bad = 0;

    always #5 CLK = ~CLK;

    assign bus_in = loop_en ? bus_out : bus_drv;

    acc_breg_alu dut (
        .CLK(CLK), .RESET(RESET), .bus_in(bus_in), .prog_in(prog_in),
        .acc_we(acc_we), .acc_load(acc_load), .acc_oe(acc_oe),
        .breg_we(breg_we), .breg_load(breg_load), .breg_oe(breg_oe),
        .alu_oe(alu_oe), .SUB(SUB), .acc_q(acc_q), .breg_q(breg_q),
        .alu_q(alu_q), .carry(carry), .zero(zero), .bus_out(bus_out),
        .bus_drive(bus_drive), .bus_conflict(bus_conflict)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // A from prog_in, B from bus_in, both in one edge.
    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        prog_in = a; bus_drv = b; acc_load = 1'b1; breg_we = 1'b1;
        step();
        acc_load = 1'b0; breg_we = 1'b0;
        #1;
    endtask

    initial begin
        RESET = 1'b0; bus_drv = 8'h00; prog_in = 8'h00; loop_en = 1'b0;
        acc_we = 0; acc_load = 0; acc_oe = 0; breg_we = 0; breg_load = 0;
        breg_oe = 0; alu_oe = 0; SUB = 0;
        #12 RESET = 1'b1;
        #1;
        chk("rst_acc", {1'b0, acc_q}, 9'h000);
        chk("rst_breg", {1'b0, breg_q}, 9'h000);
        chk("rst_alu", {1'b0, alu_q}, 9'h000);
        chk("rst_zero", {8'h00, zero}, 9'h001);
        chk("rst_carry", {8'h00, carry}, 9'h000);
        chk("rst_bus", {bus_drive, bus_out}, 9'h000);
        chk("rst_conflict", {8'h00, bus_conflict}, 9'h000);

        // Preload, then async reset mid-cycle
        acc_load = 1'b1; prog_in = 8'h5A; step(); acc_load = 1'b0;
        breg_load = 1'b1; prog_in = 8'hA5; step(); breg_load = 1'b0;
        chk("pre_acc", {1'b0, acc_q}, 9'h05A);
        chk("pre_breg", {1'b0, breg_q}, 9'h0A5);
        #2 RESET = 1'b0;
        #1;
        chk("async_acc", {1'b0, acc_q}, 9'h000);
        chk("async_breg", {1'b0, breg_q}, 9'h000);
        chk("async_zero", {8'h00, zero}, 9'h001);
        SUB = 1'b1; #1;
        chk("rst_sub_carry", {8'h00, carry}, 9'h001);
        SUB = 1'b0;

        // Reset held across an edge with a load pending
        acc_we = 1'b1; bus_drv = 8'h77;
        step();
        chk("rst_wins", {1'b0, acc_q}, 9'h000);
        RESET = 1'b1; acc_we = 1'b0;

        // Load priority
        acc_we = 1'b1; acc_load = 1'b1; bus_drv = 8'h11; prog_in = 8'h22;
        step();
        chk("we_prio", {1'b0, acc_q}, 9'h011);
        acc_we = 1'b0;
        step();
        chk("load_prog", {1'b0, acc_q}, 9'h022);
        acc_load = 1'b0;
        breg_we = 1'b1; breg_load = 1'b1; bus_drv = 8'h33; prog_in = 8'h44;
        step();
        chk("breg_we_prio", {1'b0, breg_q}, 9'h033);
        breg_we = 1'b0; breg_load = 1'b0;

        // Add
        load_ab(8'h05, 8'h03);
        chk("add", {carry, alu_q}, 9'h008);
        chk("add_zero", {8'h00, zero}, 9'h000);
        load_ab(8'hFF, 8'h01);
        chk("add_ovf", {carry, alu_q}, 9'h100);
        chk("add_ovf_zero", {8'h00, zero}, 9'h001);

        // Subtract
        SUB = 1'b1;
        load_ab(8'h05, 8'h03);
        chk("sub", {carry, alu_q}, 9'h102);
        load_ab(8'h03, 8'h05);
        chk("sub_borrow", {carry, alu_q}, 9'h0FE);
        load_ab(8'h44, 8'h44);
        chk("sub_eq", {carry, alu_q}, 9'h100);
        chk("sub_eq_zero", {8'h00, zero}, 9'h001);
        SUB = 1'b0;

        // Bus priority
        load_ab(8'h05, 8'h03);
        acc_oe = 1'b1; breg_oe = 1'b1; alu_oe = 1'b1; #1;
        chk("bus_all", {bus_drive, bus_out}, 9'h108);
        chk("conf_all", {8'h00, bus_conflict}, 9'h001);
        alu_oe = 1'b0; #1;
        chk("bus_ab", {bus_drive, bus_out}, 9'h103);
        chk("conf_ab", {8'h00, bus_conflict}, 9'h001);
        breg_oe = 1'b0; #1;
        chk("bus_a", {bus_drive, bus_out}, 9'h105);
        chk("conf_a", {8'h00, bus_conflict}, 9'h000);
        acc_oe = 1'b0; #1;
        chk("bus_none", {bus_drive, bus_out}, 9'h000);

        // ALU-to-A transfer through the looped bus
        alu_oe = 1'b1; loop_en = 1'b1; acc_we = 1'b1; #1;
        chk("xfer_pre", {1'b0, bus_out}, 9'h008);
        step();
        chk("xfer_acc", {1'b0, acc_q}, 9'h008);
        chk("xfer_alu", {1'b0, alu_q}, 9'h00B);
        step();
        chk("xfer2_acc", {1'b0, acc_q}, 9'h00B);
        chk("xfer2_breg", {1'b0, breg_q}, 9'h003);
        acc_we = 1'b0; alu_oe = 1'b0; loop_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acc_breg_alu.md
# acc_breg_alu

Eight-bit arithmetic datapath slice for the SAP-style computer: accumulator (A), B register and a combinational adder/subtractor, each with its own bus output enable. It sits between the shared 8-bit system bus and the programmer/switch input. It loads A and B from either source and drives one selected 8-bit value back toward the bus.

## Interface
- No parameters; all data paths are fixed at 8 bits.
- CLK  input  1  single system clock; all register updates on rising edge.
- RESET  input  1  asynchronous, active-low reset; clears A and B immediately.
- bus_in  input  8  current system-bus value.
- prog_in  input  8  programmer/switch data.
- acc_we  input  1  load A from bus_in.
- acc_load  input  1  load A from prog_in.
- acc_oe  input  1  drive A onto bus_out.
- breg_we  input  1  load B from bus_in.
- breg_load  input  1  load B from prog_in.
- breg_oe  input  1  drive B onto bus_out.
- alu_oe  input  1  drive ALU result onto bus_out.
- SUB  input  1  0 = A+B, 1 = A−B.
- acc_q  output  8  current A contents.
- breg_q  output  8  current B contents.
- alu_q  output  8  current ALU result.
- carry  output  1  ALU carry / no-borrow flag.
- zero  output  1  1 when alu_q == 0.
- bus_out  output  8  selected bus value; 0x00 when nothing is enabled.
- bus_drive  output  1  1 when any output enable is active.
- bus_conflict  output  1  1 when two or more output enables are active.

## Operation
- A register:
  - On a rising edge, if acc_we: A <= bus_in.
  - Else if acc_load: A <= prog_in.
  - Else hold. WE has priority over load.
- B register: same rules using breg_we, breg_load and prog_in.
- ALU, combinational from the registered A and B:
  - SUB=0: {carry, alu_q} = A + B (9-bit sum).
  - SUB=1: alu_q = (A − B) mod 256, computed as A + ~B + 1; carry = 1 when A ≥ B (no borrow).
  - zero = (alu_q == 0).
- Bus mux, combinational:
  - Priority alu_oe > breg_oe > acc_oe.
  - bus_out = 0x00 and bus_drive = 0 when no enable is active.
  - bus_conflict = (popcount of the three enables) ≥ 2. The result still follows the priority order.
- Output enables never affect register contents; OE and WE may be active in the same cycle.
- No internal bus loopback: bus_in is used exactly as presented. The integrator ties bus_out to the bus.

## Timing
- RESET low, asynchronous: A = B = 0x00 immediately.
  - Therefore alu_q = 0x00 and zero = 1.
  - carry = 0 with SUB=0; carry = 1 with SUB=1.
  - bus_out follows the enables.
- RESET release: the first load can take effect on the next rising edge.
- Load latency: 1 cycle; acc_q and breg_q show new data right after the edge.
- ALU and flags: 0 cycles after A, B or SUB change (combinational).
- bus_out, bus_drive, bus_conflict: 0-cycle combinational.
- Same-edge capture: with alu_oe=1, bus_in=bus_out and acc_we=1, A captures the pre-edge result A op B. This is the ALU-to-A transfer; it must be glitch-safe with no combinational loop inside the block.
- RESET asserted in the same cycle as a load: reset wins and the load is discarded.

## Test plan
- Reset: preload A=0x5A, B=0xA5, then pulse RESET low mid-cycle → acc_q = breg_q = 0x00 without waiting for an edge; zero=1.
- Load priority: acc_we=1, acc_load=1, bus_in=0x11, prog_in=0x22 → A=0x11 after the edge; with acc_we=0, A=0x22.
- Add: A=0x05, B=0x03, SUB=0 → alu_q=0x08, carry=0, zero=0.
- Add overflow: A=0xFF, B=0x01 → alu_q=0x00, carry=1, zero=1.
- Subtract:
  - A=0x05, B=0x03 → alu_q=0x02, carry=1.
  - A=0x03, B=0x05 → alu_q=0xFE, carry=0.
- Bus priority and transfer:
  - acc_oe = breg_oe = alu_oe = 1 with A=0x05, B=0x03, SUB=0 → bus_out=0x08, bus_drive=1, bus_conflict=1.
  - With alu_oe only, bus_in looped to bus_out and acc_we=1 → A=0x08 after the edge, then alu_q=0x0B.
